// File: rtl/alu_serial_seq.sv
// rtl/alu_serial_seq.sv - bit-serial ALU controller driving one 1-bit slice, LSB first
// Optional feature macro: SLT_OVF_FIX_EN (overflow-corrected signed less-than)
module alu_serial_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             ainvert,
    input  logic             binvert,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] a_q, b_q, result_q;
    logic [1:0]       op_q;
    logic             ainv_q, binv_q, carry_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_out_q, overflow_q, zero_q;

    logic             ai, bi, sum, carry_next, slice_bit, ovf_fin, set_bit;
    logic [WIDTH-1:0] res_fin;

    // One slice of the ripple chain, evaluated at the current bit position
    always_comb begin
        ai         = a_q[cnt_q] ^ ainv_q;
        bi         = b_q[cnt_q] ^ binv_q;
        sum        = ai ^ bi ^ carry_q;
        carry_next = (ai & bi) | (ai & carry_q) | (bi & carry_q);
        ovf_fin    = carry_q ^ carry_next;
        case (op_q)
            2'b00:   slice_bit = ai & bi;
            2'b01:   slice_bit = ai | bi;
            2'b10:   slice_bit = sum;
            default: slice_bit = 1'b0;
        endcase
    end

`ifdef SLT_OVF_FIX_EN
    assign set_bit = sum ^ ovf_fin;
`else
    assign set_bit = sum;
`endif

    // Final result as it stands once the MSB is written and the Set bit looped back
    always_comb begin
        res_fin         = result_q;
        res_fin[cnt_q]  = slice_bit;
        if (op_q == 2'b11) begin
            res_fin[0] = set_bit;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (cnt_q == LAST) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= 2'b00;
            ainv_q      <= 1'b0;
            binv_q      <= 1'b0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q      <= a;
                        b_q      <= b;
                        op_q     <= op;
                        ainv_q   <= ainvert;
                        binv_q   <= binvert;
                        carry_q  <= binvert;
                        cnt_q    <= '0;
                        result_q <= '0;
                    end
                end
                RUN: begin
                    carry_q <= carry_next;
                    cnt_q   <= cnt_q + CW'(1);
                    // Flags and the patched bit 0 land together so they are valid with done
                    if (cnt_q == LAST) begin
                        result_q    <= res_fin;
                        carry_out_q <= carry_next;
                        overflow_q  <= ovf_fin;
                        zero_q      <= (res_fin == '0);
                    end else begin
                        result_q[cnt_q] <= slice_bit;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign done      = (state == FIN);
    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_alu_serial_seq.sv
// tb/tb_alu_serial_seq.sv - directed self-checking bench for alu_serial_seq (WIDTH=8)
module tb_alu_serial_seq;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n, start;
    logic [W-1:0] a, b;
    logic [1:0]   op;
    logic         ainvert, binvert;
    logic         busy, done;
    logic [W-1:0] result;
    logic         carry_out, overflow, zero;

    int total = 0;
    int bad   = 0;
    int lat, bcnt, dcnt, nd;
    int dt [2];
    logic [W-1:0] dr [2];
    logic [W-1:0] hold_res;

`ifdef SLT_OVF_FIX_EN
    localparam logic [W-1:0] SLT_OVF_RES = 8'h01;
    localparam logic [2:0]   SLT_OVF_FLG = 3'b110;
`else
    localparam logic [W-1:0] SLT_OVF_RES = 8'h00;
    localparam logic [2:0]   SLT_OVF_FLG = 3'b111;
`endif

    alu_serial_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .op        (op),
        .ainvert   (ainvert),
        .binvert   (binvert),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic [1:0] top, input logic tai, input logic tbi);
        @(negedge clk);
        a = ta; b = tb_v; op = top; ainvert = tai; binvert = tbi; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        a = ~ta; b = ~tb_v;
        lat = 0; bcnt = 0; dcnt = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (done) begin
                dcnt++;
                if (lat == 0) lat = c;
            end
            if (!busy) break;
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; op = 2'b00; ainvert = 1'b0; binvert = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ctrl", {busy, done, carry_out, overflow, zero}, 5'b00000);
        chk("reset_result", result, 8'h00);
        rst_n = 1'b1;

        run_op(8'h7F, 8'h01, 2'b10, 1'b0, 1'b0);
        chk("add_latency", lat, 9);
        chk("add_busy", bcnt, 9);
        chk("add_dones", dcnt, 1);
        chk("add_result", result, 8'h80);
        chk("add_flags", {carry_out, overflow, zero}, 3'b010);

        run_op(8'h05, 8'h05, 2'b10, 1'b0, 1'b1);
        chk("sub_result", result, 8'h00);
        chk("sub_flags", {carry_out, overflow, zero}, 3'b101);

        run_op(8'h03, 8'h05, 2'b11, 1'b0, 1'b1);
        chk("slt_lt_result", result, 8'h01);
        chk("slt_lt_flags", {carry_out, overflow, zero}, 3'b000);

        run_op(8'h05, 8'h03, 2'b11, 1'b0, 1'b1);
        chk("slt_gt_result", result, 8'h00);
        chk("slt_gt_flags", {carry_out, overflow, zero}, 3'b101);

        run_op(8'h80, 8'h01, 2'b11, 1'b0, 1'b1);
        chk("slt_ovf_result", result, SLT_OVF_RES);
        chk("slt_ovf_flags", {carry_out, overflow, zero}, SLT_OVF_FLG);

        run_op(8'hF0, 8'h0C, 2'b00, 1'b1, 1'b1);
        chk("nor_result", result, 8'h03);
        chk("nor_busy", bcnt, 9);
        chk("nor_flags", {carry_out, overflow, zero}, 3'b100);

        // start pulses while busy must be ignored
        @(negedge clk);
        a = 8'h7F; b = 8'h01; op = 2'b10; ainvert = 1'b0; binvert = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        dcnt = 0;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            if (done) dcnt++;
            start = (c == 3 || c == 5 || c == 9);
        end
        start = 1'b0;
        chk("ignore_start_dones", dcnt, 1);
        chk("ignore_start_idle", busy, 1'b0);
        chk("ignore_start_result", result, 8'h80);

        // reset while bit 3 is due
        @(negedge clk);
        a = 8'h05; b = 8'h03; op = 2'b10; ainvert = 1'b0; binvert = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrun_reset_ctrl", {busy, done, carry_out, overflow, zero}, 5'b00000);
        chk("midrun_reset_result", result, 8'h00);
        rst_n = 1'b1;
        dcnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("midrun_reset_no_done", dcnt, 0);

        run_op(8'h05, 8'h03, 2'b10, 1'b0, 1'b0);
        chk("post_reset_latency", lat, 9);
        chk("post_reset_result", result, 8'h08);
        chk("post_reset_flags", {carry_out, overflow, zero}, 3'b000);

        // back-to-back with start held high
        @(negedge clk);
        a = 8'h12; b = 8'h40; op = 2'b01; ainvert = 1'b0; binvert = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 a = 8'hF0; b = 8'h3C; op = 2'b00;
        nd = 0; hold_res = '0; dt[0] = 0; dt[1] = 0; dr[0] = '0; dr[1] = '0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (done) begin
                if (nd < 2) begin
                    dt[nd] = c;
                    dr[nd] = result;
                end
                nd++;
            end
            if (nd == 1 && !busy) hold_res = result;
            if (nd >= 1 && busy && !done) start = 1'b0;
            if (nd >= 2 && !busy) break;
        end
        start = 1'b0;
        chk("b2b_done_count", nd, 2);
        chk("b2b_spacing", dt[1] - dt[0], 10);
        chk("b2b_result0", dr[0], 8'h52);
        chk("b2b_result1", dr[1], 8'h30);
        chk("b2b_hold_between", hold_res, 8'h52);
        chk("b2b_flags", {carry_out, overflow, zero}, 3'b100);
        repeat (3) @(negedge clk);
        chk("b2b_hold_after", result, 8'h30);
        chk("b2b_idle", {busy, done}, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
